// File: rtl/fwu_crc_check_ctrl.sv
// Sequencer for the shared byte-serial CRC-32 engine during firmware image checks:
// streams the payload into the engine, captures the LE trailer and reports the comparison.
module fwu_crc_check_ctrl #(
    parameter int LEN_W   = 24,
    parameter int TMO_W   = 16,
    parameter int TMO_CYC = 50000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             abort,
    input  logic             s_valid,
    input  logic [7:0]       s_data,
    output logic             s_ready,
    output logic             crc_init,
    output logic             crc_en,
    output logic [7:0]       crc_data,
    input  logic [31:0]      crc_value,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [1:0]       err_code,
    output logic [31:0]      calc_crc,
    output logic [31:0]      exp_crc
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_DATA,
        S_TRAIL,
        S_CHECK
    } state_t;

    localparam logic [1:0]       ERR_NONE  = 2'd0;
    localparam logic [1:0]       ERR_MISM  = 2'd1;
    localparam logic [1:0]       ERR_TMO   = 2'd2;
    localparam logic [1:0]       ERR_ABORT = 2'd3;
    // Counter value at which one more idle cycle makes TMO_CYC-1.
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TMO_CYC - 2);

    state_t             state, state_nxt;
    logic [LEN_W-1:0]   remaining;
    logic [1:0]         trail_idx;
    logic [TMO_W-1:0]   tmo_cnt;
    logic               in_stream, accept, abort_hit, tmo_hit, terminate, crc_match;

    assign in_stream = (state == S_DATA) || (state == S_TRAIL);
    assign s_ready   = in_stream && !abort;
    assign accept    = s_valid && s_ready;
    assign crc_en    = (state == S_DATA) && accept;
    assign crc_data  = s_data;
    assign crc_init  = (state == S_INIT);
    assign busy      = (state != S_IDLE);
    assign crc_match = (~crc_value == exp_crc);

    assign abort_hit = abort && (state != S_IDLE);
    assign tmo_hit   = in_stream && !accept && (tmo_cnt == TMO_LAST);
    assign terminate = abort_hit || tmo_hit;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (start) state_nxt = S_INIT;
            S_INIT:  state_nxt = (remaining != '0) ? S_DATA : S_TRAIL;
            S_DATA:  if (accept && remaining == LEN_W'(1)) state_nxt = S_TRAIL;
            S_TRAIL: if (accept && trail_idx == 2'd3) state_nxt = S_CHECK;
            S_CHECK: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (terminate) state_nxt = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            remaining <= '0;
            trail_idx <= '0;
            tmo_cnt   <= '0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_code  <= ERR_NONE;
            calc_crc  <= '0;
            exp_crc   <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: if (start) begin
                    remaining <= len;
                    pass      <= 1'b0;
                    err_code  <= ERR_NONE;
                    exp_crc   <= '0;
                end
                S_INIT: begin
                    tmo_cnt   <= '0;
                    trail_idx <= '0;
                end
                S_DATA, S_TRAIL: if (accept) begin
                    tmo_cnt <= '0;
                    if (state == S_DATA) begin
                        remaining <= remaining - LEN_W'(1);
                    end else begin
                        exp_crc[{trail_idx, 3'b000} +: 8] <= s_data;
                        trail_idx <= trail_idx + 2'd1;
                    end
                end else begin
                    tmo_cnt <= tmo_cnt + TMO_W'(1);
                end
                S_CHECK: begin
                    calc_crc <= ~crc_value;
                    pass     <= crc_match;
                    err_code <= crc_match ? ERR_NONE : ERR_MISM;
                    done     <= 1'b1;
                end
                default: ;
            endcase
            // Early termination wins over whatever the state did this cycle.
            if (terminate) begin
                pass     <= 1'b0;
                calc_crc <= ~crc_value;
                err_code <= abort_hit ? ERR_ABORT : ERR_TMO;
                done     <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fwu_crc_check_ctrl.sv
// Bench for fwu_crc_check_ctrl: models the CRC engine, drives directed and random frames,
// and checks results against a queue-based CRC-32 reference.
module tb_fwu_crc_check_ctrl;
    localparam int LEN_W   = 24;
    localparam int TMO_W   = 16;
    localparam int TMO_CYC = 8;

    logic             clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0, s_valid = 1'b0;
    logic [LEN_W-1:0] len = '0;
    logic [7:0]       s_data = '0;
    logic             s_ready, crc_init, crc_en, busy, done, pass;
    logic [7:0]       crc_data;
    logic [31:0]      crc_value, calc_crc, exp_crc, eng, want;
    logic [1:0]       err_code;
    logic [7:0]       pay[$];

    int total = 0, bad = 0, cyc = 0, t0 = 0;
    int done_cyc = 0, last_acc = 0, en_cnt = 0, init_cnt = 0, done_cnt = 0;

    always #5 clk = ~clk;

    fwu_crc_check_ctrl #(.LEN_W(LEN_W), .TMO_W(TMO_W), .TMO_CYC(TMO_CYC)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .abort(abort),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .crc_init(crc_init), .crc_en(crc_en), .crc_data(crc_data), .crc_value(crc_value),
        .busy(busy), .done(done), .pass(pass), .err_code(err_code),
        .calc_crc(calc_crc), .exp_crc(exp_crc)
    );

    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    // Finished CRC-32 over the first n bytes of q.
    function automatic logic [31:0] crc_ref(input logic [7:0] q[$], input int n);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) c = crc_step(c, q[i]);
        return ~c;
    endfunction

    assign crc_value = eng;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst)           eng <= '0;
        else if (crc_init) eng <= 32'hFFFFFFFF;
        else if (crc_en)   eng <= crc_step(eng, crc_data);
    end

    always @(negedge clk) begin
        if (crc_en)   en_cnt   <= en_cnt + 1;
        if (crc_init) init_cnt <= init_cnt + 1;
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
        if (s_valid && s_ready) last_acc <= cyc;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_frame(input int n);
        en_cnt = 0; init_cnt = 0; done_cnt = 0;
        len   = LEN_W'(n);
        start = 1'b1;
        t0    = cyc;
        step(1);
        start = 1'b0;
        chk("clear_on_start", {pass, err_code, exp_crc}, 35'h0);
    endtask

    task automatic offer_byte(input logic [7:0] b, input int gap);
        int n;
        s_valid = 1'b0;
        step(gap);
        s_valid = 1'b1;
        s_data  = b;
        n = 0;
        while (!s_ready && n < 50) begin
            step(1);
            n++;
        end
        if (!s_ready) chk("ready_wait", s_ready, 1);
        step(1);
        s_valid = 1'b0;
    endtask

    task automatic wait_done(input int lim);
        int n;
        n = 0;
        while (!done && n < lim) begin
            step(1);
            n++;
        end
        chk("done_seen", done, 1);
        step(1);
        chk("done_pulse", done, 0);
        step(1);
    endtask

    task automatic run_frame(input logic [7:0] p[$], input logic [31:0] trl,
                             input int maxgap, input int start_at);
        logic [7:0] all[$];
        all = p;
        for (int i = 0; i < 4; i++) all.push_back(trl[8*i +: 8]);
        start_frame(p.size());
        for (int i = 0; i < all.size(); i++) begin
            if (i == start_at) begin
                start = 1'b1;
                len   = '0;
            end
            offer_byte(all[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
            start = 1'b0;
        end
        wait_done(100);
    endtask

    initial begin
        step(3);
        chk("rst_outs", {busy, done, pass, err_code, s_ready, crc_init, crc_en}, 0);
        chk("rst_crc", {calc_crc, exp_crc}, 0);
        rst = 1'b0;
        step(1);

        // Check string, correct trailer, back-to-back bytes.
        pay = {};
        for (int i = 0; i < 9; i++) pay.push_back(8'h31 + 8'(i));
        run_frame(pay, 32'hCBF43926, 0, -1);
        chk("ok_latency", done_cyc - t0, 16);
        chk("ok_pass", {pass, err_code}, 3'b100);
        chk("ok_calc", calc_crc, 32'hCBF43926);
        chk("ok_exp", exp_crc, 32'hCBF43926);
        chk("ok_en_cnt", en_cnt, 9);
        chk("ok_init_cnt", init_cnt, 1);
        chk("ok_idle", busy, 0);

        run_frame(pay, 32'hCAF43926, 0, -1);
        chk("mis_pass", {pass, err_code}, 3'b001);
        chk("mis_calc", calc_crc, 32'hCBF43926);
        chk("mis_exp", exp_crc, 32'hCAF43926);

        // Empty payload.
        pay = {};
        run_frame(pay, 32'h0, 0, -1);
        chk("z_pass", {pass, err_code}, 3'b100);
        chk("z_calc", calc_crc, 32'h0);
        chk("z_en_cnt", en_cnt, 0);
        chk("z_latency", done_cyc - t0, 7);
        run_frame(pay, 32'hFFFFFFFF, 0, -1);
        chk("zf_err", {pass, err_code}, 3'b001);
        chk("zf_exp", exp_crc, 32'hFFFFFFFF);

        // Random gaps below the timeout, plus a start pulse while busy.
        for (int i = 0; i < 9; i++) pay.push_back(8'h31 + 8'(i));
        run_frame(pay, 32'hCBF43926, TMO_CYC - 2, 4);
        chk("gap_pass", {pass, err_code}, 3'b100);
        chk("gap_calc", calc_crc, 32'hCBF43926);
        chk("busy_start_init", init_cnt, 1);
        chk("busy_start_en", en_cnt, 9);

        // Stall after two of four bytes.
        pay = {};
        for (int i = 0; i < 4; i++) pay.push_back(8'($urandom_range(0, 255)));
        start_frame(4);
        offer_byte(pay[0], 0);
        offer_byte(pay[1], 0);
        wait_done(50);
        chk("tmo_lat", done_cyc - last_acc, 8);
        chk("tmo_err", {pass, err_code}, 3'b010);
        chk("tmo_calc", calc_crc, crc_ref(pay, 2));
        chk("tmo_exp", exp_crc, 32'h0);
        chk("tmo_done_cnt", done_cnt, 1);

        // Abort while the third data byte is offered.
        pay = {};
        for (int i = 0; i < 5; i++) pay.push_back(8'($urandom_range(0, 255)));
        start_frame(5);
        offer_byte(pay[0], 0);
        offer_byte(pay[1], 0);
        s_valid = 1'b1;
        s_data  = pay[2];
        abort   = 1'b1;
        #1;
        chk("abort_gate", {s_ready, crc_en}, 2'b00);
        step(1);
        chk("abort_done", {done, busy}, 2'b10);
        chk("abort_err", {pass, err_code}, 3'b011);
        chk("abort_calc", calc_crc, crc_ref(pay, 2));
        chk("abort_en_cnt", en_cnt, 2);
        s_valid = 1'b0;
        step(2);
        chk("idle_abort", {busy, done, err_code}, 4'b0011);
        chk("idle_abort_cnt", done_cnt, 1);
        abort = 1'b0;

        // Reset in the middle of the trailer.
        start_frame(2);
        for (int i = 0; i < 4; i++) offer_byte(8'($urandom_range(0, 255)), 0);
        chk("trail_busy", busy, 1);
        rst = 1'b1;
        step(1);
        chk("mid_rst_outs", {busy, done, pass, err_code, s_ready}, 0);
        chk("mid_rst_crc", {calc_crc, exp_crc}, 0);
        rst = 1'b0;
        step(10);
        chk("mid_rst_nodone", done_cnt, 0);

        // Random frames, some with a corrupted trailer.
        for (int f = 0; f < 6; f++) begin
            int n;
            n = int'($urandom_range(1, 16));
            pay = {};
            for (int i = 0; i < n; i++) pay.push_back(8'($urandom_range(0, 255)));
            want = crc_ref(pay, n);
            if ($urandom_range(0, 2) == 0) want = want ^ (32'h1 << $urandom_range(0, 31));
            run_frame(pay, want, int'($urandom_range(0, TMO_CYC - 2)), -1);
            chk("rnd_calc", calc_crc, crc_ref(pay, n));
            chk("rnd_exp", exp_crc, want);
            chk("rnd_pass", {pass, err_code},
                (want == crc_ref(pay, n)) ? 3'b100 : 3'b001);
            chk("rnd_en_cnt", en_cnt, n);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fwu_crc_check_ctrl.md
Name: fwu_crc_check_ctrl

Overview:
- Sequences the shared byte-serial CRC-32 (IEEE, reflected, init 0xFFFFFFFF) engine during firmware-image verification.
- On start it initialises the engine and streams a payload of programmed length into it over a valid/ready byte interface.
- It then captures a 4-byte little-endian CRC trailer and compares it with the final inverted engine value.
- Reports pass/fail with an error code to the update FSM.

Parameters:
LEN_W, 24, width of payload byte count
TMO_W, 16, width of inter-byte timeout counter
TMO_CYC, 50000, cycles without accepted byte in DATA/TRAIL before timeout (must be >=2, < 2**TMO_W)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  pulse; begin check (ignored while busy)
len  in  LEN_W  payload bytes excluding trailer, sampled on accepted start
abort  in  1  level/pulse; terminate current check
s_valid  in  1  byte stream valid
s_data  in  8  byte stream data
s_ready  out  1  byte accepted when s_valid & s_ready
crc_init  out  1  to engine: reload 0xFFFFFFFF
crc_en  out  1  to engine: consume crc_data this cycle
crc_data  out  8  to engine: byte
crc_value  in  32  from engine: running register (updates edge after crc_en)
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse, result valid
pass  out  1  1 = CRC matched, no error
err_code  out  2  0 none, 1 mismatch, 2 timeout, 3 abort
calc_crc  out  32  ~crc_value at termination
exp_crc  out  32  trailer value received

Behaviour:
- Reset: state IDLE; s_ready, crc_init, crc_en, busy, done, pass = 0; err_code = 0; calc_crc, exp_crc, byte counter, timeout counter = 0.
- Handshake: s_ready = (state==DATA || state==TRAIL) && !abort.
  - crc_en = (state==DATA) && s_valid && s_ready.
  - crc_data = s_data, combinational.
- IDLE: start=1 -> latch len into remaining; clear pass, err_code, exp_crc; go INIT.
- INIT, 1 cycle: crc_init=1. Next state DATA if remaining!=0, else TRAIL.
- DATA: each accepted byte decrements remaining. The accept with remaining==1 goes to TRAIL with trail index 0.
- TRAIL: accepted bytes fill exp_crc little-endian (byte0 -> [7:0] ... byte3 -> [31:24]). The engine is not fed. Fourth accept -> CHECK.
- CHECK, 1 cycle:
  - calc_crc <= ~crc_value; pass <= (~crc_value == exp_crc); err_code <= match ? 0 : 1.
  - done <= 1 (registered, visible next cycle); go IDLE.
  - The engine has settled because at least 4 cycles separate the last crc_en from CHECK.
- Timeout: counter clears on INIT and on each accepted byte, and increments each DATA/TRAIL cycle without an accept. Reaching TMO_CYC-1 -> terminate with err_code=2.
- Abort: in any non-IDLE state it terminates with err_code=3. It overrides a same-cycle handshake (s_ready already low) and timeout. Abort in IDLE is ignored.
- Termination (timeout/abort): next cycle pass=0, calc_crc=~crc_value, done pulse; return IDLE. exp_crc holds partial bytes.
- Results (pass, err_code, calc_crc, exp_crc) hold until next accepted start.
- busy drops in the same cycle done rises. start in that cycle is accepted.
- Latency, len=N with s_valid held high: start at cycle 0, INIT cycle 1, data cycles 2..N+1, trailer N+2..N+5, CHECK N+6, done high at cycle N+7.
- rst mid-operation returns to reset values immediately. No done is generated.
- remaining is width LEN_W with no wrap. len up to 2**LEN_W-1 supported.

Test Plan:
- len=9, bytes "123456789" (0x31..0x39), trailer 26 39 F4 CB, s_valid continuous -> done at cycle 16 after start, pass=1, err_code=0, calc_crc=0xCBF43926, exactly 9 crc_en pulses, 1 crc_init.
- Same stream, trailer 26 39 F4 CA -> pass=0, err_code=1, calc_crc=0xCBF43926, exp_crc=0xCAF43926.
- len=0, trailer 00 00 00 00 -> no crc_en, pass=1, calc_crc=0x00000000. With trailer FF FF FF FF -> err_code=1.
- TMO_CYC=8, len=4, stall s_valid after byte 2 -> done 8 cycles after last accept, err_code=2, pass=0. Random s_valid gaps <7 cycles on "123456789" -> still pass=1.
- abort asserted with s_valid high during 3rd data byte -> that byte not accepted (s_ready=0, crc_en=0), done next cycle, err_code=3. start while busy ignored. rst during TRAIL -> IDLE, no done, outputs at reset values.
